// File: rtl/axi4_burst_mgr.sv
`default_nettype none
// ============================================================================
// Module      : axi4_burst_mgr
// Description : Single-outstanding AXI4 burst manager. It turns a local
//               write or read burst request into AXI4 INCR transactions and
//               reports completion with a one-cycle req_done pulse plus an
//               error status.
//
// Ports
//   clk, reset                     : clock, asynchronous active-high reset
//   req_addr, req_len              : burst start address, beats minus one
//   req_wr, req_rd                 : write / read request, held to req_done
//   req_wdata, req_wstrb, req_wack : write beat data/strobe, beat consumed
//   req_rdata, req_rack            : read beat data, read beat valid
//   req_done, req_err, busy        : completion pulse, error, not idle
//   aw*, w*, b*                    : AXI4 write address/data/response
//   ar*, r*                        : AXI4 read address/data
//
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_burst_mgr #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32,
  parameter int NODE      = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  // Local request side
  input  logic [ADDRWIDTH-1:0]   req_addr,
  input  logic [7:0]             req_len,
  input  logic                   req_wr,
  input  logic                   req_rd,
  input  logic [DATAWIDTH-1:0]   req_wdata,
  input  logic [DATAWIDTH/8-1:0] req_wstrb,
  output logic                   req_wack,
  output logic [DATAWIDTH-1:0]   req_rdata,
  output logic                   req_rack,
  output logic                   req_done,
  output logic                   req_err,
  output logic                   busy,
  // AXI4 write address channel
  output logic [ADDRWIDTH-1:0]   awaddr,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic                   awvalid,
  input  logic                   awready,
  // AXI4 write data channel
  output logic [DATAWIDTH-1:0]   wdata,
  output logic [DATAWIDTH/8-1:0] wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  // AXI4 write response channel
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready,
  // AXI4 read address channel
  output logic [ADDRWIDTH-1:0]   araddr,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic                   arvalid,
  input  logic                   arready,
  // AXI4 read data channel
  input  logic [DATAWIDTH-1:0]   rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready
);

  localparam logic [2:0] C_AXSIZE     = 3'($clog2(DATAWIDTH/8));
  localparam logic [1:0] C_BURST_INCR = 2'b01;

  // Elaboration-time parameter sanity checks
  if ((DATAWIDTH != 32) && (DATAWIDTH != 64) && (DATAWIDTH != 128)) begin : g_dw_chk
    $error("axi4_burst_mgr: DATAWIDTH must be 32, 64 or 128");
  end
  if (NODE < 0) begin : g_node_chk
    $error("axi4_burst_mgr: NODE must be non-negative");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t                 r_state;
  logic [ADDRWIDTH-1:0]   r_addr;
  logic [7:0]             r_len;
  // One bit wider than the length so a read that overruns the requested
  // length is still distinguishable from a correct one.
  logic [8:0]             r_cnt;
  logic                   r_err;
  logic                   r_aw_done;
  logic                   r_w_done;

  logic                   w_aw_fire;
  logic                   w_r_fire;
  logic                   w_aw_ok;
  logic                   w_w_ok;
  logic                   w_cnt_at_len;

  // Only the SLVERR/DECERR bit of the responses matters here.
  logic                   w_unused;
  assign w_unused = &{1'b0, bresp[0], rresp[0]};

  assign w_cnt_at_len = (r_cnt == {1'b0, r_len});
  assign w_aw_fire    = awvalid & awready;
  assign w_r_fire     = rready & rvalid;

  assign req_wack  = wvalid & wready;
  assign req_rack  = w_r_fire;
  assign req_rdata = rdata;
  assign busy      = (r_state != IDLE);

  assign awaddr  = awvalid ? r_addr : {ADDRWIDTH{1'bx}};
  assign araddr  = arvalid ? r_addr : {ADDRWIDTH{1'bx}};
  assign awlen   = r_len;
  assign arlen   = r_len;
  assign awsize  = C_AXSIZE;
  assign arsize  = C_AXSIZE;
  assign awburst = C_BURST_INCR;
  assign arburst = C_BURST_INCR;

  assign wdata = wvalid ? req_wdata : {DATAWIDTH{1'bx}};
  assign wstrb = req_wstrb;
  assign wlast = wvalid & w_cnt_at_len;

  // AW and W complete independently; either may finish first, or both in
  // the same cycle.
  assign w_aw_ok = r_aw_done | w_aw_fire;
  assign w_w_ok  = r_w_done  | (req_wack & wlast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      arvalid   <= 1'b0;
      bready    <= 1'b0;
      rready    <= 1'b0;
      req_done  <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      req_done <= 1'b0;
      req_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          // The requester still holds its request during the req_done
          // cycle, so nothing is accepted then.
          if (!req_done && (req_wr || req_rd)) begin
            r_addr    <= req_addr;
            r_len     <= req_len;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (req_wr) begin
              r_state <= WRITE;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              r_state <= RADDR;
              arvalid <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (w_aw_fire) begin
            awvalid   <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (req_wack) begin
            r_cnt <= r_cnt + 9'd1;
            if (wlast) begin
              wvalid   <= 1'b0;
              r_w_done <= 1'b1;
            end
          end
          if (w_aw_ok && w_w_ok) begin
            r_state <= WRESP;
            bready  <= 1'b1;
          end
        end

        WRESP: begin
          if (bvalid) begin
            bready   <= 1'b0;
            req_done <= 1'b1;
            req_err  <= bresp[1];
            r_state  <= IDLE;
          end
        end

        RADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= RDATA;
          end
        end

        RDATA: begin
          if (w_r_fire) begin
            // Saturate so a runaway slave cannot wrap the count back into
            // a matching value.
            if (r_cnt != 9'h1FF) begin
              r_cnt <= r_cnt + 9'd1;
            end
            if (rlast) begin
              rready   <= 1'b0;
              req_done <= 1'b1;
              req_err  <= r_err | rresp[1] | ~w_cnt_at_len;
              r_state  <= IDLE;
            end else begin
              // A non-last beat at or beyond the final index means rlast
              // is missing where it was due.
              r_err <= r_err | rresp[1] | (r_cnt >= {1'b0, r_len});
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/axi4_burst_mgr.md
AXI4_BURST_MGR -- requirements
Module: axi4_burst_mgr

Interface
REQ-001 Parameter ADDRWIDTH, default 32, AXI address width.
REQ-002 Parameter DATAWIDTH, default 32, AXI and local data width; legal values are 32, 64 and 128.
REQ-003 Parameter NODE, default 0, node number passed through to node-specific logic.
REQ-004 Ports clk, in, 1, single clock; all logic is on posedge clk.
REQ-005 Ports reset, in, 1, asynchronous active-high reset.
REQ-006 Ports req_addr, in, ADDRWIDTH, burst start address; sampled at request acceptance.
REQ-007 Ports req_len, in, 8, beats minus one (0 to 255); sampled at request acceptance.
REQ-008 Ports req_wr / req_rd, in, 1 each, write / read burst request; held until req_done.
REQ-009 Ports req_wdata / req_wstrb, in, DATAWIDTH / DATAWIDTH/8, current write beat.
REQ-010 Ports req_wack, out, 1, write beat consumed this cycle.
REQ-011 Ports req_rdata, out, DATAWIDTH, read beat data.
REQ-012 Ports req_rack, out, 1, read beat valid this cycle.
REQ-013 Ports req_done / req_err, out, 1 each, burst complete pulse / error status qualified by req_done.
REQ-014 Ports busy, out, 1, block is not in IDLE.
REQ-015 Ports awaddr/awlen/awsize/awburst/awvalid out, awready in; ar* likewise: AXI4 address channels, widths ADDRWIDTH/8/3/2/1/1.
REQ-016 Ports wdata/wstrb/wlast/wvalid out, wready in: AXI4 write data channel.
REQ-017 Ports bresp/bvalid in, bready out; rdata/rresp/rlast/rvalid in, rready out: AXI4 response channels.

Function
REQ-018 The block SHALL use states IDLE, WRITE, WRESP, RADDR and RDATA.
REQ-019 In IDLE, req_wr SHALL move the block to WRITE and req_rd SHALL move it to RADDR on the next edge; req_wr wins if both are high.
REQ-020 On acceptance, the block SHALL register req_addr and req_len into awaddr/araddr and awlen/arlen, and SHALL clear the beat counter.
REQ-021 awsize/arsize SHALL be the constant log2(DATAWIDTH/8), and awburst/arburst SHALL be the constant 2'b01 (INCR); no 4KB splitting is performed.
REQ-022 awaddr, araddr and wdata SHALL be driven X whenever their channel valid is low.
REQ-023 In WRITE, awvalid SHALL be high until the first awready cycle, and SHALL stay low after that acceptance.
REQ-024 In WRITE, wvalid SHALL be high until the last beat is accepted.
REQ-025 The AW and W channels SHALL be independent, so the last W beat may precede the AW acceptance.
REQ-026 wdata/wstrb SHALL equal req_wdata/req_wstrb, and req_wack SHALL equal wvalid & wready.
REQ-027 The beat counter SHALL increment on each req_wack, and wlast SHALL be high when wvalid is high and the counter equals the registered length.
REQ-028 WRITE SHALL move to WRESP once both AW and the last W beat are accepted, including when both occur in the same cycle.
REQ-029 In WRESP, bready SHALL be 1; on bvalid, req_done SHALL pulse for one cycle with req_err = bresp[1], and the state SHALL return to IDLE.
REQ-030 In RADDR, arvalid SHALL be high until arready, then the state SHALL move to RDATA.
REQ-031 In RDATA, rready SHALL be 1, req_rdata SHALL equal rdata, and req_rack SHALL equal rvalid.
REQ-032 The read error flag SHALL OR in rresp[1] on each beat.
REQ-033 On rvalid & rlast, req_done SHALL pulse and the state SHALL return to IDLE.
REQ-034 req_err on a read SHALL be (accumulated error) OR (rlast beat count differs from length+1).
REQ-035 A beat arriving with the counter already at length while rlast is low SHALL set the error flag; the block SHALL keep accepting beats until rlast.
REQ-036 req_done SHALL be registered, so the local side may reassert req_wr/req_rd in the cycle after req_done.
REQ-037 A new request SHALL not be accepted in the req_done cycle.
REQ-038 busy SHALL be high in every state other than IDLE.

Reset
REQ-039 While reset is high, the state SHALL be IDLE and awvalid, wvalid, arvalid, bready, rready, req_wack, req_rack, req_done, req_err and busy SHALL be 0.
REQ-040 While reset is high, the beat counter, registered length and error flag SHALL be 0.
REQ-041 Reset asserted mid-burst SHALL abandon the AXI transaction without completing it or issuing req_done.
REQ-042 Operation SHALL resume from IDLE on the first posedge clk after reset deasserts.

Verification
REQ-043 Single write: req_addr=0x100, req_len=0, awready=wready=1 -> one beat with wlast=1 and awlen=0; bvalid with bresp=0 -> req_done=1, req_err=0.
REQ-044 Write, W before AW: req_len=3 with awready held low for 6 cycles -> 4 beats with wlast on beat 4; AW accepted at cycle 6; req_done one cycle after bvalid.
REQ-045 Read burst with stalls: req_len=7 with rvalid toggling -> 8 req_rack pulses with matching data; rlast on beat 8 -> req_done, req_err=0.
REQ-046 Read error paths: rresp=2'b10 on beat 2 of 4 -> req_err=1 at done; early rlast on beat 3 of 4 -> req_err=1.
REQ-047 Simultaneous requests: req_wr=req_rd=1 in IDLE -> the write is performed first, then the read is accepted after req_done.
REQ-048 Reset mid-burst: reset asserted during beat 2 of a write -> all valids 0 immediately and busy=0; a following read completes normally.
